// File: rtl/call_return_ctrl.sv
// call_return_ctrl: fetch-stage PC sequencer driving a return-address stack for CALL/RET.
module call_return_ctrl #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    localparam int DW = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] target,
    output logic             busy,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] stk_read_PC,
    output logic             stk_push,
    output logic             stk_pop,
    input  logic [WIDTH-1:0] stk_write_PC,
    output logic [DW-1:0]    depth,
    output logic             overflow,
    output logic             underflow
);
    typedef enum logic [2:0] {IDLE, CALL_SETUP, CALL_PUSH, RET_POP, RET_WAIT} state_t;
    state_t state;
    logic [WIDTH-1:0] tgt;
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            pc          <= RESET_PC;
            stk_read_PC <= '0;
            stk_push    <= 1'b0;
            stk_pop     <= 1'b0;
            depth       <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (op_valid) begin
                    case (op)
                        2'b00: pc <= pc + 1'b1;
                        2'b01: pc <= target;
                        2'b10: if (depth == DW'(DEPTH)) begin
                            overflow <= 1'b1;
                            pc       <= target;
                        end else begin
                            state       <= CALL_SETUP;
                            busy        <= 1'b1;
                            stk_read_PC <= pc + 1'b1;
                            tgt         <= target;
                        end
                        2'b11: if (depth == '0) begin
                            underflow <= 1'b1;
                            pc        <= pc + 1'b1;
                        end else begin
                            state   <= RET_POP;
                            busy    <= 1'b1;
                            stk_pop <= 1'b1;
                        end
                    endcase
                end
                // read_PC has been stable a full cycle before push rises
                CALL_SETUP: begin
                    state    <= CALL_PUSH;
                    stk_push <= 1'b1;
                end
                CALL_PUSH: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    stk_push <= 1'b0;
                    pc       <= tgt;
                    depth    <= depth + 1'b1;
                end
                RET_POP: begin
                    state   <= RET_WAIT;
                    stk_pop <= 1'b0;
                end
                // stack output has had a full cycle to settle after the pop
                RET_WAIT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    pc    <= stk_write_PC;
                    depth <= depth - 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_call_return_ctrl.sv
// tb_call_return_ctrl: scoreboard bench for call_return_ctrl with a behavioural return-address stack.
module tb_call_return_ctrl;
    localparam int W = 18;
    localparam int D = 32;
    localparam int DW = 6;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic op_valid = 1'b0;
    logic [1:0] op = 2'b00;
    logic [W-1:0] target = '0;
    logic busy, stk_push, stk_pop, overflow, underflow;
    logic [W-1:0] pc, stk_read_PC;
    logic [W-1:0] stk_write_PC = '0;
    logic [DW-1:0] depth;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    call_return_ctrl #(.WIDTH(W), .DEPTH(D), .RESET_PC('0)) dut (
        .clock(clock), .reset(reset), .op_valid(op_valid), .op(op), .target(target),
        .busy(busy), .pc(pc), .stk_read_PC(stk_read_PC), .stk_push(stk_push),
        .stk_pop(stk_pop), .stk_write_PC(stk_write_PC), .depth(depth),
        .overflow(overflow), .underflow(underflow)
    );

    // stack model: acts on rising push/pop
    logic [W-1:0] mem [0:63];
    logic [6:0] sp = '0;
    logic push_q = 1'b0, pop_q = 1'b0;
    always @(posedge clock) begin
        push_q <= stk_push;
        pop_q  <= stk_pop;
        if (reset) sp <= '0;
        else if (stk_push && !push_q) begin
            mem[sp[5:0]] <= stk_read_PC;
            sp <= sp + 7'd1;
        end else if (stk_pop && !pop_q) begin
            sp <= sp - 7'd1;
            stk_write_PC <= mem[sp[5:0] - 6'd1];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic mon_push_q = 1'b0, mon_pop_q = 1'b0;
    always @(negedge clock) begin
        if (!reset) begin
            if (stk_push && stk_pop) chk("push_pop_excl", 32'(stk_push & stk_pop), 0);
            if (stk_push && mon_push_q) chk("push_one_cycle", 32'(stk_push), 0);
            if (stk_pop && mon_pop_q) chk("pop_one_cycle", 32'(stk_pop), 0);
        end
        mon_push_q <= stk_push;
        mon_pop_q  <= stk_pop;
    end

    typedef struct packed {
        logic [W-1:0]  pc;
        logic [DW-1:0] depth;
        logic          ovf;
        logic          udf;
    } exp_t;
    exp_t sb[$];
    logic [W-1:0] m_pc = '0;
    logic [DW-1:0] m_depth = '0;
    logic m_ovf = 1'b0, m_udf = 1'b0;
    logic [W-1:0] m_stk[$];

    task automatic push_exp();
        sb.push_back('{m_pc, m_depth, m_ovf, m_udf});
    endtask

    task automatic expect_state();
        exp_t e;
        e = sb.pop_front();
        chk("pc", 32'(pc), 32'(e.pc));
        chk("depth", 32'(depth), 32'(e.depth));
        chk("overflow", 32'(overflow), 32'(e.ovf));
        chk("underflow", 32'(underflow), 32'(e.udf));
    endtask

    task automatic do_rst();
        @(negedge clock);
        reset = 1'b1;
        op_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        m_pc = '0; m_depth = '0; m_ovf = 1'b0; m_udf = 1'b0;
        m_stk.delete();
        chk("rst_pc", 32'(pc), 0);
        chk("rst_depth", 32'(depth), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_push", 32'(stk_push), 0);
        chk("rst_pop", 32'(stk_pop), 0);
        chk("rst_read_pc", 32'(stk_read_PC), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_udf", 32'(underflow), 0);
    endtask

    task automatic do_op(input logic [1:0] o, input logic [W-1:0] t, input bit hold);
        logic [W-1:0] ra;
        bit seq;
        ra = '0;
        seq = 0;
        @(negedge clock);
        op_valid = 1'b1;
        op = o;
        target = t;
        case (o)
            2'b00: m_pc = m_pc + 1'b1;
            2'b01: m_pc = t;
            2'b10: if (m_depth == D) begin
                m_ovf = 1'b1;
                m_pc = t;
            end else begin
                ra = m_pc + 1'b1;
                m_stk.push_back(ra);
                m_pc = t;
                m_depth = m_depth + 1'b1;
                seq = 1;
            end
            2'b11: if (m_depth == 0) begin
                m_udf = 1'b1;
                m_pc = m_pc + 1'b1;
            end else begin
                m_pc = m_stk.pop_back();
                m_depth = m_depth - 1'b1;
                seq = 1;
            end
        endcase
        push_exp();
        @(negedge clock);
        if (hold) op = 2'b00;
        else op_valid = 1'b0;
        chk("busy_e0", 32'(busy), 32'(seq));
        if (o == 2'b10 && seq) begin
            chk("read_pc_e0", 32'(stk_read_PC), 32'(ra));
            chk("push_e0", 32'(stk_push), 0);
            @(negedge clock);
            chk("push_e1", 32'(stk_push), 1);
            chk("busy_e1", 32'(busy), 1);
            @(negedge clock);
            chk("push_e2", 32'(stk_push), 0);
            chk("busy_e2", 32'(busy), 0);
        end else if (o == 2'b11 && seq) begin
            chk("pop_e0", 32'(stk_pop), 1);
            @(negedge clock);
            chk("pop_e1", 32'(stk_pop), 0);
            chk("busy_e1", 32'(busy), 1);
            @(negedge clock);
            chk("busy_e2", 32'(busy), 0);
        end else begin
            chk("push_idle", 32'(stk_push), 0);
            chk("pop_idle", 32'(stk_pop), 0);
        end
        expect_state();
        if (hold) begin
            m_pc = m_pc + 1'b1;
            push_exp();
            @(negedge clock);
            op_valid = 1'b0;
            expect_state();
        end
    endtask

    initial begin
        do_rst();
        repeat (3) do_op(2'b00, '0, 0);
        do_op(2'b01, 18'h00010, 0);
        do_op(2'b10, 18'h00200, 0);
        do_op(2'b11, '0, 0);
        do_op(2'b01, 18'h00050, 0);
        do_op(2'b10, 18'h00100, 0);
        do_op(2'b10, 18'h00200, 0);
        do_op(2'b10, 18'h00300, 0);
        repeat (3) do_op(2'b11, '0, 0);
        for (int i = 0; i < D; i++) do_op(2'b10, W'(32'h1000 + i * 8), 0);
        do_op(2'b10, 18'h3FFFF, 0);
        do_op(2'b00, '0, 0);
        repeat (2) do_op(2'b11, '0, 0);
        do_rst();
        do_op(2'b01, 18'd5, 0);
        do_op(2'b11, '0, 0);
        do_op(2'b10, 18'h00040, 1);
        @(negedge clock);
        op_valid = 1'b1;
        op = 2'b10;
        target = 18'h00077;
        @(negedge clock);
        op_valid = 1'b0;
        @(negedge clock);
        chk("midcall_push", 32'(stk_push), 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midrst_push", 32'(stk_push), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_pc", 32'(pc), 0);
        chk("midrst_depth", 32'(depth), 0);
        chk("midrst_ovf", 32'(overflow), 0);
        chk("midrst_udf", 32'(underflow), 0);
        @(negedge clock);
        chk("midrst_push_after", 32'(stk_push), 0);
        chk("midrst_pc_after", 32'(pc), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
